// File: rtl/icache_ctrl_pkg.sv
// rtl/icache_ctrl_pkg.sv - shared constants and FSM encoding for the instruction cache
//
// Purpose : word/block geometry and refill state encoding used by icache_ctrl
//           and icache_array.
// Ports   : none (package).
package icache_ctrl_pkg;

    localparam int WORD_SIZE  = 32;    // bits per instruction word
    localparam int BLOCK_SIZE = 1024;  // bits per cache line (128 bytes)
    localparam int OFFSET_W   = 7;     // byte offset width within a line

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped line storage: valid bits, tags and line data
//
// Purpose : LINES entries of {valid, tag, data}. Asynchronous read port,
//           one synchronous write port (sets valid), per-line valid clear,
//           valid bits cleared asynchronously by rst.
// Ports   : clk, rst            clock, async active-high reset
//           ridx_i              read index
//           rvalid_o/rtag_o/rdata_o  read data for ridx_i
//           clr_i, clr_idx_i    clear valid of one line at the clock edge
//           we_i, widx_i, wtag_i, wdata_i  line write, marks the line valid
module icache_array #(
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 22,
    parameter int DATA_W = 1024,
    parameter int LINES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic              rvalid_o,
    output logic [TAG_W-1:0]  rtag_o,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  clr_idx_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [TAG_W-1:0]  wtag_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            // Clear and write never target a line in the same cycle: the
            // controller clears on refill start and writes on commit.
            if (clr_i) begin
                valid_q[clr_idx_i] <= 1'b0;
            end
            if (we_i) begin
                valid_q[widx_i] <= 1'b1;
            end
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache with beat-serial refill
//
// Purpose : combinational block lookup on a fetch address; on a miss the
//           block is refilled word by word from instruction memory.
// Ports   : clk, rst            clock, async active-high reset
//           in                  fetch byte address
//           out                 whole block, word 0 in the top bits
//           miss                high while out is not the block for in
//           mem_req, mem_addr   refill request and block-aligned address
//           mem_ack, mem_data   one refill beat, words delivered 0..31
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int WORD_SIZE   = icache_ctrl_pkg::WORD_SIZE,
    parameter int BLOCK_WORDS = 32,
    parameter int LINES       = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            in,
    output logic [WORD_SIZE*BLOCK_WORDS-1:0] out,
    output logic                             miss,
    output logic                             mem_req,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic                             mem_ack,
    input  logic [WORD_SIZE-1:0]             mem_data
);

    localparam int BLOCK_BITS = WORD_SIZE * BLOCK_WORDS;
    localparam int IDX_W      = $clog2(LINES);
    localparam int TAG_W      = ADDR_WIDTH - OFFSET_W - IDX_W;
    localparam int CNT_W      = $clog2(BLOCK_WORDS);

    state_t                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BLOCK_BITS-1:0]   fill_q, fill_d;

    logic [IDX_W-1:0]        in_idx;
    logic [TAG_W-1:0]        in_tag;
    logic                    arr_valid;
    logic [TAG_W-1:0]        arr_tag;
    logic [BLOCK_BITS-1:0]   arr_data;
    logic                    hit;
    logic                    clr;
    logic                    we;
    logic                    unused_offset;

    assign in_idx        = in[OFFSET_W +: IDX_W];
    assign in_tag        = in[ADDR_WIDTH-1 -: TAG_W];
    assign unused_offset = ^in[OFFSET_W-1:0];

    icache_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (BLOCK_BITS),
        .LINES  (LINES)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .ridx_i    (in_idx),
        .rvalid_o  (arr_valid),
        .rtag_o    (arr_tag),
        .rdata_o   (arr_data),
        .clr_i     (clr),
        .clr_idx_i (in_idx),
        .we_i      (we),
        .widx_i    (mem_addr_q[OFFSET_W +: IDX_W]),
        .wtag_i    (mem_addr_q[ADDR_WIDTH-1 -: TAG_W]),
        .wdata_i   (fill_q)
    );

    // Lookups are suppressed outside IDLE so a line under refill or commit
    // is never presented as a hit.
    assign hit      = arr_valid && (arr_tag == in_tag) && (state_q == IDLE);
    assign out      = hit ? arr_data : '0;
    assign miss     = !hit;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        clr        = 1'b0;
        we         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    mem_addr_d = {in[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    mem_req_d  = 1'b1;
                    cnt_d      = '0;
                    clr        = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    // Beats arrive in word order, so shifting in from the
                    // bottom leaves word 0 in the top bits after the last beat.
                    fill_d = {fill_q[BLOCK_BITS-WORD_SIZE-1:0], mem_data};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
                        mem_req_d = 1'b0;
                        state_d   = COMMIT;
                    end
                end
            end
            COMMIT: begin
                we      = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed self-checking bench for icache_ctrl
module tb_icache_ctrl;

    logic          clk;
    logic          rst;
    logic [31:0]   in;
    logic [1023:0] out;
    logic          miss;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_data;

    int total = 0;
    int bad   = 0;

    icache_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .out      (out),
        .miss     (miss),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int i);
        return out[(31 - i) * 32 +: 32];
    endfunction

    task automatic check_block(input string tag, input logic [31:0] base);
        for (int i = 0; i < 32; i++) begin
            check(tag, word_of(i), base + i);
        end
    endtask

    // Memory responder: beats first..last of base+i, each preceded by gap idle cycles.
    task automatic serve(input logic [31:0] addr, input logic [31:0] base,
                         input int gap, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            for (int g = 0; g < gap; g++) begin
                check("req_in_gap", {31'd0, mem_req}, 32'd1);
                check("addr_in_gap", mem_addr, addr);
                step();
            end
            mem_ack  = 1'b1;
            mem_data = base + i;
            check("req_in_fill", {31'd0, mem_req}, 32'd1);
            check("addr_in_fill", mem_addr, addr);
            step();
            mem_ack  = 1'b0;
            mem_data = 32'hDEAD_BEEF;
        end
    endtask

    // Start a miss at the current in, fill with base, then check commit timing.
    task automatic refill(input logic [31:0] addr, input logic [31:0] base, input int gap);
        check("miss_before_req", {31'd0, miss}, 32'd1);
        step();
        check("req_rise", {31'd0, mem_req}, 32'd1);
        check("req_addr", mem_addr, addr);
        serve(addr, base, gap, 0, 31);
        check("req_drop", {31'd0, mem_req}, 32'd0);
        check("miss_in_commit", {31'd0, miss}, 32'd1);
        step();
        check("hit_after_commit", {31'd0, miss}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in       = 32'h0000_0080;
        mem_ack  = 1'b0;
        mem_data = 32'h0;
        step();
        step();
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_miss", {31'd0, miss}, 32'd1);
        check("rst_out_hi", word_of(0), 32'h0);
        check("rst_out_lo", word_of(31), 32'h0);
        check("rst_out_any", {31'd0, |out}, 32'd0);

        // Cold miss on index 1
        rst = 1'b0;
        #1;
        refill(32'h0000_0080, 32'h1000_0000, 0);
        check("cold_w0", word_of(0), 32'h1000_0000);
        check("cold_w31", word_of(31), 32'h1000_001F);

        // Hit with a different offset, and a stray ack in IDLE
        in = 32'h0000_00FC;
        #1;
        check("reuse_miss", {31'd0, miss}, 32'd0);
        check_block("reuse_blk", 32'h1000_0000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);
        check("idle_ack_miss", {31'd0, miss}, 32'd0);
        step();
        check("reuse_req", {31'd0, mem_req}, 32'd0);

        // Conflict on index 1, then back to the evicted tag
        in = 32'h0000_0480;
        #1;
        refill(32'h0000_0480, 32'h2000_0000, 0);
        check("conf_w0", word_of(0), 32'h2000_0000);
        in = 32'h0000_0080;
        #1;
        refill(32'h0000_0080, 32'h3000_0000, 0);
        check("back_w31", word_of(31), 32'h3000_001F);

        // Address change after 10 beats of the 0x100 fill
        in = 32'h0000_0100;
        #1;
        check("mid_miss", {31'd0, miss}, 32'd1);
        step();
        check("mid_req", {31'd0, mem_req}, 32'd1);
        check("mid_addr", mem_addr, 32'h0000_0100);
        serve(32'h0000_0100, 32'h4000_0000, 0, 0, 9);
        in = 32'h0000_0200;
        serve(32'h0000_0100, 32'h4000_0000, 0, 10, 31);
        check("mid_req_drop", {31'd0, mem_req}, 32'd0);
        step();
        check("mid_new_miss", {31'd0, miss}, 32'd1);
        check("mid_idle_req", {31'd0, mem_req}, 32'd0);

        // Stalled memory: acks every 3rd cycle for 0x200
        refill(32'h0000_0200, 32'h5000_0000, 2);
        check_block("stall_blk", 32'h5000_0000);
        in = 32'h0000_0100;
        #1;
        check("mid_old_miss", {31'd0, miss}, 32'd0);
        check_block("mid_old_blk", 32'h4000_0000);

        // Reset after beat 5 of a fill for 0x300
        in = 32'h0000_0300;
        #1;
        step();
        serve(32'h0000_0300, 32'h7000_0000, 0, 0, 4);
        rst = 1'b1;
        #1;
        check("rstmid_req", {31'd0, mem_req}, 32'd0);
        check("rstmid_miss", {31'd0, miss}, 32'd1);
        step();
        rst = 1'b0;
        in  = 32'h0000_0080;
        #1;
        refill(32'h0000_0080, 32'h6000_0000, 0);
        check("restart_w0", word_of(0), 32'h6000_0000);
        check("restart_w31", word_of(31), 32'h6000_001F);
        in = 32'h0000_0300;
        #1;
        check("partial_invalid", {31'd0, miss}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
